// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction fetch queue.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] PC_STEP = 32'd4;

    typedef enum logic {
        FQ_IDLE = 1'b0,
        FQ_BUSY = 1'b1
    } fq_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

    localparam int ENTRY_W = $bits(fq_entry_t);

    // Clears the byte-offset bits so every fetch address is word aligned.
    function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] pc);
        return pc & ~(PC_STEP - 32'd1);
    endfunction

endpackage

// File: rtl/mips_sync_fifo.sv
// Synchronous FIFO with flush; head word is held at zero while empty.
module mips_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mips_fetch_queue.sv
// Sequential instruction fetcher with a prefetch FIFO, redirect flush and halt.
module mips_fetch_queue
    import mips_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    input  logic        halt
);

    localparam int AW = $clog2(DEPTH);

    fq_state_t    state;
    logic [31:0]  fetch_pc;
    logic         stale;

    logic         transfer;
    logic         accept;
    logic         pop;
    logic         issue;
    logic         full;
    logic         empty;
    logic [AW:0]  count;
    logic [AW+1:0] occ_next;
    fq_entry_t    push_entry;
    fq_entry_t    head;

    always_comb begin
        transfer   = (state == FQ_BUSY) && imem_ack;
        accept     = transfer && !stale && !redir_valid && (!full || pop);
        pop        = !empty && inst_ready;
        occ_next   = {1'b0, count} + (AW+2)'(accept) - (AW+2)'(pop);
        // A new request reserves a FIFO slot, so issue only while one is still free.
        issue      = (occ_next < (AW+2)'(DEPTH)) && !halt && !redir_valid &&
                     ((state == FQ_IDLE) || (transfer && !stale));
        push_entry = '{pc: imem_addr, instr: imem_rdata};
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= FQ_IDLE;
            fetch_pc  <= RESET_PC;
            imem_addr <= RESET_PC;
            stale     <= 1'b0;
        end else begin
            if (issue) begin
                state     <= FQ_BUSY;
                imem_addr <= fetch_pc;
                fetch_pc  <= fetch_pc + PC_STEP;
            end else if (transfer) begin
                state <= FQ_IDLE;
            end
            // An outstanding request survives a redirect; its data is dropped on arrival.
            if (transfer) begin
                stale <= 1'b0;
            end else if (redir_valid && (state == FQ_BUSY)) begin
                stale <= 1'b1;
            end
            if (redir_valid) fetch_pc <= word_align(redir_pc);
        end
    end

    mips_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (accept),
        .pop   (pop),
        .flush (redir_valid),
        .din   (push_entry),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign imem_req   = (state == FQ_BUSY);
    assign inst_valid = !empty;
    assign inst_data  = head.instr;
    assign inst_pc    = head.pc;

endmodule
